// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and BGR pixel layout for all video blocks.
package vga_pkg;

  localparam int H_TOTAL  = 800;
  localparam int H_SYNC   = 96;
  localparam int H_START  = 143;
  localparam int H_ACTIVE = 640;
  localparam int V_TOTAL  = 525;
  localparam int V_SYNC   = 2;
  localparam int V_START  = 35;
  localparam int V_ACTIVE = 480;

  localparam int BLUE_MSB  = 11;
  localparam int GREEN_MSB = 7;
  localparam int RED_MSB   = 3;
  localparam int CH_W      = 4;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // Split a frame-buffer word into DAC channels, blanked when not in the active area.
  function automatic rgb_t gate_bgr(input logic en, input logic [11:0] bgr);
    rgb_t c;
    c = '0;
    if (en) begin
      c.r = bgr[RED_MSB   -: CH_W];
      c.g = bgr[GREEN_MSB -: CH_W];
      c.b = bgr[BLUE_MSB  -: CH_W];
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Line/frame counters plus registered sync, active-area and address decode.
module vga_timing #(
  parameter int H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_START  = vga_pkg::H_START,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_START  = vga_pkg::V_START,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
  input  logic       vga_clk,
  input  logic       clrn,
  output logic [9:0] x_addr,
  output logic [8:0] y_addr,
  output logic       read,
  output logic       hs,
  output logic       vs
);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FIRST = 10'(H_START);
  localparam logic [9:0] H_END   = 10'(H_START + H_ACTIVE - 1);
  localparam logic [9:0] V_FIRST = 10'(V_START);
  localparam logic [9:0] V_END   = 10'(V_START + V_ACTIVE - 1);
  localparam logic [9:0] H_SW    = 10'(H_SYNC);
  localparam logic [9:0] V_SW    = 10'(V_SYNC);

  logic [9:0] h_count, v_count;
  logic       h_wrap, h_act, v_act;

  assign h_wrap = (h_count == H_LAST);
  assign h_act  = (h_count >= H_FIRST) && (h_count <= H_END);
  assign v_act  = (v_count >= V_FIRST) && (v_count <= V_END);

  // Outputs decode the pre-edge counters, so they trail the counters by one clock.
  always_ff @(posedge vga_clk) begin
    if (clrn) begin
      h_count <= '0;
      v_count <= '0;
      x_addr  <= '0;
      y_addr  <= '0;
      read    <= 1'b0;
      hs      <= 1'b0;
      vs      <= 1'b0;
    end else begin
      h_count <= h_wrap ? '0 : h_count + 10'd1;
      if (h_wrap)
        v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
      x_addr <= h_count - H_FIRST;
      y_addr <= 9'(v_count - V_FIRST);
      hs     <= (h_count >= H_SW);
      vs     <= (v_count >= V_SW);
      read   <= h_act && v_act;
    end
  end

endmodule

// File: rtl/vgac.sv
// VGA controller: timing generator plus colour gating of frame-buffer pixels onto the DAC.
module vgac
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_START  = vga_pkg::H_START,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_START  = vga_pkg::V_START,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic [11:0] d_in_BGR,
  output logic [8:0]  Y_Addr,
  output logic [9:0]  X_Addr,
  output logic        read,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs
);

  rgb_t pix;

  vga_timing #(
    .H_TOTAL (H_TOTAL),  .H_SYNC (H_SYNC),  .H_START (H_START),  .H_ACTIVE (H_ACTIVE),
    .V_TOTAL (V_TOTAL),  .V_SYNC (V_SYNC),  .V_START (V_START),  .V_ACTIVE (V_ACTIVE)
  ) u_timing (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .x_addr  (X_Addr),
    .y_addr  (Y_Addr),
    .read    (read),
    .hs      (hs),
    .vs      (vs)
  );

  // Frame buffer answers within the cycle, so the DAC path is purely combinational.
  always_comb begin
    pix = gate_bgr(read, d_in_BGR);
    r   = pix.r;
    g   = pix.g;
    b   = pix.b;
  end

endmodule

// File: tb/tb_vgac.sv
// Bench: full-size vgac checked line-level, a shrunken-timing vgac checked over whole frames.
module tb_vgac;

  logic        vga_clk = 1'b0;
  logic        clrn    = 1'b1;
  logic [11:0] d_in_BGR = 12'hABC;

  logic [8:0] fy, sy;
  logic [9:0] fx, sx;
  logic       fread, sread, fhs, shs, fvs, svs;
  logic [3:0] fr, fg, fb, sr, sg, sb;

  vgac u_full (
    .vga_clk(vga_clk), .clrn(clrn), .d_in_BGR(d_in_BGR),
    .Y_Addr(fy), .X_Addr(fx), .read(fread), .r(fr), .g(fg), .b(fb), .hs(fhs), .vs(fvs)
  );

  vgac #(
    .H_TOTAL(40), .H_SYNC(6), .H_START(9), .H_ACTIVE(24),
    .V_TOTAL(20), .V_SYNC(2), .V_START(4), .V_ACTIVE(12)
  ) u_small (
    .vga_clk(vga_clk), .clrn(clrn), .d_in_BGR(d_in_BGR),
    .Y_Addr(sy), .X_Addr(sx), .read(sread), .r(sr), .g(sg), .b(sb), .hs(shs), .vs(svs)
  );

  always #20 vga_clk = ~vga_clk;

  int   total = 0;
  int   bad   = 0;
  int   kf    = 0;     // non-reset edges since the last reset edge
  logic rst_edge = 1'b0;
  logic started  = 1'b0;

  always @(posedge vga_clk) begin
    started <= 1'b1;
    if (clrn) begin
      kf       <= 0;
      rst_edge <= 1'b1;
    end else begin
      kf       <= kf + 1;
      rst_edge <= 1'b0;
    end
  end

  // Data pattern: mostly 0xABC, a short window of varied words to exercise channel routing.
  logic [11:0] pat [4];
  initial begin
    pat[0] = 12'h123; pat[1] = 12'hF0F; pat[2] = 12'h5A6; pat[3] = 12'h0E1;
  end
  always @(posedge vga_clk) begin
    #1;
    if (kf >= 28300 && kf < 28340) d_in_BGR = pat[kf % 4];
    else d_in_BGR = 12'hABC;
  end

  // Expected {read,hs,vs,X,Y,r,g,b} when the counters stood at linear position pos.
  function automatic logic [33:0] model(input int pos, input int ht, input int hsw, input int hst,
                                        input int ha, input int vt, input int vsw, input int vst,
                                        input int va, input logic [11:0] d);
    int h, v;
    logic rd;
    logic [9:0] x;
    logic [8:0] y;
    logic [11:0] c;
    h  = pos % ht;
    v  = (pos / ht) % vt;
    rd = (h >= hst) && (h < hst + ha) && (v >= vst) && (v < vst + va);
    x  = 10'((h - hst) & 1023);
    y  = 9'((v - vst) & 511);
    c  = rd ? {d[3:0], d[7:4], d[11:8]} : 12'h000;
    return {rd, (h >= hsw), (v >= vsw), x, y, c};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, kf);
    end
  endtask

  // Compare process: both instances against the model every cycle, plus frame totals on the small one.
  int   s_cnt, s_reads, s_vslow, s_maxx, s_maxy;
  logic s_started = 1'b0;
  logic prev_svs  = 1'b0;
  initial begin
    logic [33:0] ef, es, af, as;
    forever begin
      @(negedge vga_clk);
      if (started) begin
        af = {fread, fhs, fvs, fx, fy, fr, fg, fb};
        as = {sread, shs, svs, sx, sy, sr, sg, sb};
        if (rst_edge) begin
          ef = '0;
          es = '0;
        end else begin
          ef = model(kf - 1, 800, 96, 143, 640, 525, 2, 35, 480, d_in_BGR);
          es = model(kf - 1, 40, 6, 9, 24, 20, 2, 4, 12, d_in_BGR);
        end
        total += 2;
        if (af !== ef) begin
          bad++;
          $display("FAIL full_model k=%0d: got %h expected %h", kf, af, ef);
        end
        if (as !== es) begin
          bad++;
          $display("FAIL small_model k=%0d: got %h expected %h", kf, as, es);
        end

        if (rst_edge) begin
          s_started = 1'b0;
          prev_svs  = 1'b0;
        end else begin
          if (prev_svs && !svs) begin
            if (s_started) begin
              chk("small_frame_period", s_cnt, 800);
              chk("small_read_count", s_reads, 288);
              chk("small_vs_low", s_vslow, 80);
              chk("small_max_x", s_maxx, 23);
              chk("small_max_y", s_maxy, 11);
            end
            s_started = 1'b1;
            s_cnt = 0; s_reads = 0; s_vslow = 0; s_maxx = 0; s_maxy = 0;
          end
          s_cnt++;
          if (!svs) s_vslow++;
          if (sread) begin
            s_reads++;
            if (int'(sx) > s_maxx) s_maxx = int'(sx);
            if (int'(sy) > s_maxy) s_maxy = int'(sy);
          end
          prev_svs = svs;
        end
      end
    end
  end

  task automatic wait_k(input int n);
    int guard;
    guard = 0;
    while (kf < n && guard < 60000) begin
      @(negedge vga_clk);
      guard++;
    end
    if (kf != n) begin
      total++;
      bad++;
      $display("FAIL wait_k: got k=%0d expected %0d", kf, n);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_hs"}, fhs, 0);
    chk({name, "_vs"}, fvs, 0);
    chk({name, "_read"}, fread, 0);
    chk({name, "_x"}, fx, 0);
    chk({name, "_y"}, fy, 0);
    chk({name, "_rgb"}, {fr, fg, fb}, 0);
  endtask

  initial begin
    clrn = 1'b1;
    repeat (3) begin
      @(negedge vga_clk);
      chk_idle("reset");
    end
    @(posedge vga_clk);
    #1 clrn = 1'b0;

    wait_k(1);
    chk("k1_x", fx, 881);
    chk("k1_y", fy, 477);
    chk("k1_hs", fhs, 0);
    wait_k(96);    chk("hs_low_end", fhs, 0);
    wait_k(97);    chk("hs_rise", fhs, 1);
    wait_k(800);   chk("hs_high_end", fhs, 1);
    wait_k(801);   chk("hs_period", fhs, 0);
    wait_k(1600);  chk("vs_low_end", fvs, 0);
    wait_k(1601);  chk("vs_rise", fvs, 1);
    wait_k(28143); chk("pre_active_read", fread, 0);
    wait_k(28144);
    chk("first_read", fread, 1);
    chk("first_x", fx, 0);
    chk("first_y", fy, 0);
    chk("abc_r", fr, 4'hC);
    chk("abc_g", fg, 4'hB);
    chk("abc_b", fb, 4'hA);
    wait_k(28783);
    chk("last_x_read", fread, 1);
    chk("last_x", fx, 639);
    wait_k(28784);
    chk("blank_read", fread, 0);
    chk("blank_rgb", {fr, fg, fb}, 0);

    // Counters now sit at h=400, v=36: one reset edge mid-line.
    wait_k(29200);
    clrn = 1'b1;
    @(posedge vga_clk);
    #1 clrn = 1'b0;
    @(negedge vga_clk);
    chk_idle("midreset");
    wait_k(1);
    chk("rs_k1_x", fx, 881);
    chk("rs_k1_hs", fhs, 0);
    chk("rs_k1_vs", fvs, 0);
    wait_k(97);   chk("rs_hs_rise", fhs, 1);
    wait_k(801);  chk("rs_hs_fall", fhs, 0);
    wait_k(1601); chk("rs_vs_rise", fvs, 1);
    wait_k(1700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
